// File: rtl/pdm_mic_capture_pkg.sv
// Shared audio definitions for the PDM capture path: capture FSM encoding,
// default timing constants and the PCM sample width shared with PWM playback.
package pdm_mic_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam int DEF_CLK_DIV = 40;
    localparam int DEF_DECIM   = 255;
    localparam int DEF_DEPTH   = 8192;
    localparam int DEF_ADDR_W  = 13;
    localparam int PCM_W       = 8;

    function automatic logic state_is_busy(input cap_state_e s);
        return (s == ST_ARM) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/pdm_mic_capture_if.sv
// Sample RAM write port: one-cycle strobe with address and PCM data.
interface pdm_mic_capture_if
    import pdm_mic_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PCM_W-1:0]  wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pdm_mic_capture_decimator.sv
// PDM front end: free-running mic bit clock, input synchroniser and a
// ones-counting decimator producing one 8-bit window result per DECIM bits.
module pdm_decimator
    import pdm_mic_capture_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DECIM   = DEF_DECIM
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             mic_data,
    output logic             mic_clk,
    output logic             win_valid,
    output logic [PCM_W-1:0] win_result
);
    localparam int HALF  = CLK_DIV / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BIT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic             mic_clk_r;
    logic [1:0]       sync_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [PCM_W-1:0] acc_r;
    logic [PCM_W-1:0] result_r;
    logic             win_valid_r;
    logic             half_end_s;
    logic             strobe_s;
    logic             last_bit_s;

    // Divider terminal count and the rising-edge bit strobe
    always_comb begin
        half_end_s = 1'b0;
        strobe_s   = 1'b0;
        last_bit_s = 1'b0;
        if (div_cnt_r == DIV_W'(HALF - 1)) begin
            half_end_s = 1'b1;
            strobe_s   = ~mic_clk_r;
        end else begin
            half_end_s = 1'b0;
        end
        if (bit_cnt_r == BIT_W'(DECIM - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Bit clock divider, running regardless of capture state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            mic_clk_r <= 1'b0;
        end else if (half_end_s) begin
            div_cnt_r <= '0;
            mic_clk_r <= ~mic_clk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous PDM stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], mic_data};
        end
    end

    // Window accumulator; result and win_valid appear together, acc clears
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r   <= '0;
            acc_r       <= '0;
            result_r    <= '0;
            win_valid_r <= 1'b0;
        end else begin
            win_valid_r <= 1'b0;
            if (strobe_s) begin
                if (last_bit_s) begin
                    bit_cnt_r   <= '0;
                    acc_r       <= '0;
                    result_r    <= acc_r + PCM_W'(sync_r[1]);
                    win_valid_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    acc_r     <= acc_r + PCM_W'(sync_r[1]);
                end
            end
        end
    end

    assign mic_clk    = mic_clk_r;
    assign win_valid  = win_valid_r;
    assign win_result = result_r;

endmodule

// File: rtl/pdm_mic_capture.sv
// PDM microphone recorder: decimated PCM samples written sequentially to an
// external sample RAM under record/stop control.
module pdm_mic_capture
    import pdm_mic_capture_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DECIM   = DEF_DECIM,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = DEF_ADDR_W
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                record,
    input  logic                stop,
    input  logic                mic_data,
    output logic                mic_clk,
    output logic                mic_lrsel,
    pdm_mic_capture_if.master   wr,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     sample_count
);
    localparam int CNT_W = ADDR_W + 1;

    cap_state_e        state_r;
    cap_state_e        state_nxt_s;
    logic              launch_s;
    logic              win_valid_s;
    logic [PCM_W-1:0]  win_result_s;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [PCM_W-1:0]  wr_data_r;
    logic [CNT_W-1:0]  sample_count_r;
    logic              busy_r;
    logic              done_r;

    pdm_decimator #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM)
    ) u_decim (
        .clk        (clk),
        .rst        (rst),
        .mic_data   (mic_data),
        .mic_clk    (mic_clk),
        .win_valid  (win_valid_s),
        .win_result (win_result_s)
    );

    // Next state and write launch; record overrides everything, stop blocks new writes
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        if (record) begin
            state_nxt_s = ST_ARM;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_ARM: begin
                    if (win_valid_s) begin
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        state_nxt_s = ST_DONE;
                    end else if (wr_en_r && (sample_count_r == CNT_W'(DEPTH - 1))) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                        launch_s    = win_valid_s;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register with registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= state_is_busy(state_nxt_s);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Write port and sample counter; count advances the cycle after each strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_r        <= 1'b0;
            wr_addr_r      <= '0;
            wr_data_r      <= '0;
            sample_count_r <= '0;
        end else begin
            wr_en_r <= launch_s;
            if (launch_s) begin
                wr_addr_r <= sample_count_r[ADDR_W-1:0];
                wr_data_r <= win_result_s;
            end
            if (record) begin
                wr_addr_r      <= '0;
                sample_count_r <= '0;
            end else if (wr_en_r) begin
                sample_count_r <= sample_count_r + CNT_W'(1);
            end
        end
    end

    assign mic_lrsel    = 1'b0;
    assign wr.wr_en     = wr_en_r;
    assign wr.wr_addr   = wr_addr_r;
    assign wr.wr_data   = wr_data_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = sample_count_r;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Self-checking bench for pdm_mic_capture: two instances (DEPTH 4 and 8) with a
// fast bit clock; expectations come from window arithmetic on the driven stream.
module tb_pdm_mic_capture;
    localparam int CLK_DIV = 4;
    localparam int DECIM   = 255;
    localparam int WIN     = CLK_DIV * DECIM;
    localparam int ADDR_W  = 13;
    localparam int D4      = 4;
    localparam int D8      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rec4 = 1'b0, stop4 = 1'b0, rec8 = 1'b0, stop8 = 1'b0;
    logic mic_data = 1'b0;
    logic mic_clk4, lr4, busy4, done4, mic_clk8, lr8, busy8, done8;
    logic [ADDR_W:0] cnt4, cnt8;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit toggle_en = 1'b0;
    logic prev_mc = 1'b0;
    int q4a[$], q4d[$], q4c[$], q8a[$], q8d[$];

    pdm_mic_capture_if #(.ADDR_W(ADDR_W)) wr4_if();
    pdm_mic_capture_if #(.ADDR_W(ADDR_W)) wr8_if();

    pdm_mic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .DEPTH(D4), .ADDR_W(ADDR_W)) dut4 (
        .clk(clk), .rst(rst), .record(rec4), .stop(stop4), .mic_data(mic_data),
        .mic_clk(mic_clk4), .mic_lrsel(lr4), .wr(wr4_if.master),
        .busy(busy4), .done(done4), .sample_count(cnt4));

    pdm_mic_capture #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .DEPTH(D8), .ADDR_W(ADDR_W)) dut8 (
        .clk(clk), .rst(rst), .record(rec8), .stop(stop8), .mic_data(mic_data),
        .mic_clk(mic_clk8), .mic_lrsel(lr8), .wr(wr8_if.master),
        .busy(busy8), .done(done8), .sample_count(cnt8));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every high wr_en cycle is one RAM write
    always @(negedge clk) begin
        if (wr4_if.wr_en === 1'b1) begin
            q4a.push_back(int'(wr4_if.wr_addr));
            q4d.push_back(int'(wr4_if.wr_data));
            q4c.push_back(cyc);
        end
        if (wr8_if.wr_en === 1'b1) begin
            q8a.push_back(int'(wr8_if.wr_addr));
            q8d.push_back(int'(wr8_if.wr_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en && mic_clk4 && !prev_mc) mic_data = ~mic_data;
        prev_mc = mic_clk4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (wr4_if.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr4_if.wr_en); end
        n_cmp++; if (wr4_if.wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr4_if.wr_addr); end
        n_cmp++; if (wr4_if.wr_data !== 8'd0) begin n_bad++; $display("FAIL reset_wr_data: got %0d want 0", wr4_if.wr_data); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done4); end
        n_cmp++; if (cnt4 !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", cnt4); end
        n_cmp++; if (mic_clk4 !== 1'b0) begin n_bad++; $display("FAIL reset_mic_clk: got %b want 0", mic_clk4); end
        n_cmp++; if (lr4 !== 1'b0) begin n_bad++; $display("FAIL reset_lrsel: got %b want 0", lr4); end
        rst = 1'b0;
        repeat (10) tick();
        n_cmp++; if (lr8 !== 1'b0) begin n_bad++; $display("FAIL lrsel_const: got %b want 0", lr8); end
    endtask

    // Held level or toggling stream on the DEPTH=4 instance
    task automatic test_capture(input logic lvl, input bit tog, input string nm);
        int base, t_rec, n, lat;
        toggle_en = 1'b0;
        mic_data = lvl;
        prev_mc = mic_clk4;
        toggle_en = tog;
        repeat ($urandom_range(20, 300)) tick();
        rec4 = 1'b1; tick(); rec4 = 1'b0;
        t_rec = cyc;
        base = q4a.size();
        n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", nm, busy4); end
        for (int k = 0; k < 6 * WIN && done4 !== 1'b1; k++) tick();
        n_cmp++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL %s_done_timeout: got %b want 1", nm, done4); end
        repeat (WIN + 10) tick();
        n = q4a.size() - base;
        n_cmp++; if (n != D4) begin n_bad++; $display("FAIL %s_write_count: got %0d want %0d", nm, n, D4); end
        for (int i = 0; i < n && i < D4; i++) begin
            n_cmp++; if (q4a[base+i] != i) begin n_bad++; $display("FAIL %s_addr%0d: got %0d want %0d", nm, i, q4a[base+i], i); end
            if (tog) begin
                n_cmp++;
                if (q4d[base+i] != DECIM / 2 && q4d[base+i] != DECIM / 2 + 1) begin
                    n_bad++; $display("FAIL %s_data%0d: got %0d want %0d or %0d", nm, i, q4d[base+i], DECIM / 2, DECIM / 2 + 1);
                end
            end else begin
                n_cmp++; if (q4d[base+i] != (lvl ? DECIM : 0)) begin n_bad++; $display("FAIL %s_data%0d: got %0d want %0d", nm, i, q4d[base+i], lvl ? DECIM : 0); end
            end
            if (i > 0) begin
                n_cmp++; if (q4c[base+i] - q4c[base+i-1] != WIN) begin n_bad++; $display("FAIL %s_gap%0d: got %0d want %0d", nm, i, q4c[base+i] - q4c[base+i-1], WIN); end
            end
        end
        if (n > 0) begin
            lat = q4c[base] - t_rec;
            n_cmp++; if (lat <= WIN || lat > 2 * WIN + 2) begin n_bad++; $display("FAIL %s_first_latency: got %0d want in (%0d,%0d]", nm, lat, WIN, 2 * WIN + 2); end
        end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL %s_busy_end: got %b want 0", nm, busy4); end
        n_cmp++; if (cnt4 !== (ADDR_W+1)'(D4)) begin n_bad++; $display("FAIL %s_count_end: got %0d want %0d", nm, cnt4, D4); end
        toggle_en = 1'b0;
    endtask

    task automatic test_record_stop_same();
        rec8 = 1'b1; stop8 = 1'b1; tick(); rec8 = 1'b0; stop8 = 1'b0;
        n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL recstop_busy: got %b want 1", busy8); end
        n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL recstop_done: got %b want 0", done8); end
        tick();
        n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL recstop_busy_hold: got %b want 1", busy8); end
    endtask

    task automatic test_stop();
        int base, n;
        logic lvl;
        lvl = 1'($urandom_range(0, 1));
        mic_data = lvl;
        repeat ($urandom_range(10, 200)) tick();
        rec8 = 1'b1; tick(); rec8 = 1'b0;
        base = q8a.size();
        for (int k = 0; k < 5 * WIN && q8a.size() - base < 3; k++) tick();
        n_cmp++; if (q8a.size() - base < 3) begin n_bad++; $display("FAIL stop_wait3_timeout: got %0d writes want 3", q8a.size() - base); end
        repeat ($urandom_range(0, 400)) tick();
        stop8 = 1'b1; tick(); stop8 = 1'b0;
        repeat (3 * WIN) tick();
        n = q8a.size() - base;
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL stop_write_count: got %0d want 3", n); end
        for (int i = 0; i < n && i < 3; i++) begin
            n_cmp++; if (q8a[base+i] != i) begin n_bad++; $display("FAIL stop_addr%0d: got %0d want %0d", i, q8a[base+i], i); end
            n_cmp++; if (q8d[base+i] != (lvl ? DECIM : 0)) begin n_bad++; $display("FAIL stop_data%0d: got %0d want %0d", i, q8d[base+i], lvl ? DECIM : 0); end
        end
        n_cmp++; if (done8 !== 1'b1) begin n_bad++; $display("FAIL stop_done: got %b want 1", done8); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy8); end
        n_cmp++; if (cnt8 !== (ADDR_W+1)'(3)) begin n_bad++; $display("FAIL stop_count: got %0d want 3", cnt8); end
    endtask

    task automatic test_restart();
        int base, n;
        mic_data = 1'($urandom_range(0, 1));
        repeat ($urandom_range(10, 200)) tick();
        rec4 = 1'b1; tick(); rec4 = 1'b0;
        base = q4a.size();
        for (int k = 0; k < 4 * WIN && q4a.size() - base < 2; k++) tick();
        n_cmp++; if (q4a.size() - base < 2) begin n_bad++; $display("FAIL restart_wait2_timeout: got %0d writes want 2", q4a.size() - base); end
        repeat ($urandom_range(1, 500)) tick();
        rec4 = 1'b1; tick(); rec4 = 1'b0;
        base = q4a.size();
        n_cmp++; if (cnt4 !== '0) begin n_bad++; $display("FAIL restart_count_clear: got %0d want 0", cnt4); end
        for (int k = 0; k < 4 * WIN && q4a.size() - base < 3; k++) tick();
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL restart_done_early: got %b want 0", done4); end
        for (int k = 0; k < 2 * WIN && done4 !== 1'b1; k++) tick();
        n_cmp++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL restart_done_timeout: got %b want 1", done4); end
        n = q4a.size() - base;
        n_cmp++; if (n != D4) begin n_bad++; $display("FAIL restart_write_count: got %0d want %0d", n, D4); end
        for (int i = 0; i < n && i < D4; i++) begin
            n_cmp++; if (q4a[base+i] != i) begin n_bad++; $display("FAIL restart_addr%0d: got %0d want %0d", i, q4a[base+i], i); end
        end
        n_cmp++; if (cnt4 !== (ADDR_W+1)'(D4)) begin n_bad++; $display("FAIL restart_count: got %0d want %0d", cnt4, D4); end
    endtask

    task automatic test_rst_mid();
        int base, rises;
        logic pm;
        mic_data = 1'($urandom_range(0, 1));
        rec4 = 1'b1; tick(); rec4 = 1'b0;
        base = q4a.size();
        for (int k = 0; k < 4 * WIN && q4a.size() - base < 1; k++) tick();
        n_cmp++; if (q4a.size() - base < 1) begin n_bad++; $display("FAIL rst_wait1_timeout: got %0d writes want 1", q4a.size() - base); end
        repeat ($urandom_range(10, 500)) tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy4); end
        n_cmp++; if (cnt4 !== '0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", cnt4); end
        n_cmp++; if (mic_clk4 !== 1'b0) begin n_bad++; $display("FAIL rst_mic_clk: got %b want 0", mic_clk4); end
        n_cmp++; if (wr4_if.wr_addr !== '0) begin n_bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr4_if.wr_addr); end
        repeat (5) tick();
        base = q4a.size();
        rst = 1'b0;
        rises = 0;
        pm = mic_clk4;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mic_clk4 && !pm) rises++;
            pm = mic_clk4;
        end
        n_cmp++; if (rises < 2) begin n_bad++; $display("FAIL rst_mic_clk_restart: got %0d rises want >=2", rises); end
        repeat (3 * WIN) tick();
        n_cmp++; if (q4a.size() != base) begin n_bad++; $display("FAIL rst_no_write: got %0d writes want 0", q4a.size() - base); end
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL rst_idle_busy: got %b want 0", busy4); end
    endtask

    initial begin
        logic first;
        test_reset();
        first = 1'($urandom_range(0, 1));
        test_capture(first, 1'b0, "level_a");
        test_capture(~first, 1'b0, "level_b");
        test_capture(1'b0, 1'b1, "toggle");
        test_record_stop_same();
        test_stop();
        test_restart();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
